ascon_enc_arbiter: RTL and testbench

//  Shares one ASCON-128 encryption core (start/fin handshake, 128b key/nonce, 40b AD/PT) among NREQ requesters.

---
 rtl/ascon_enc_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ascon_enc_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_enc_arbiter.sv
// ascon_enc_arbiter
//   Lets NREQ requesters share one ASCON-128 encryption core. Arbitration is
//   round-robin. The arbiter captures the winning requester's operands, pulses
//   core_start, waits for core_fin, and then returns CT/tag tagged with the
//   requester id. Only one job is in flight at a time.
//
//   Optional feature (define macro ASCON_ARB_TIMEOUT_EN): a watchdog runs while
//   the arbiter waits for the core. If it expires, the arbiter returns rsp_err=1
//   with zeroed CT/tag. Without the macro, WAIT holds indefinitely and rsp_err
//   is tied to 0.
//
// Ports
//   clk, rst                          clock (rising edge), async active-high reset
//   req_valid/req_ready               per-requester handshake (req_ready is one-hot)
//   req_key/req_nonce [NREQ*128]      packed operands, requester i at [i*128+:128]
//   req_ad/req_pt     [NREQ*40]       packed operands, requester i at [i*40+:40]
//   rsp_valid/rsp_ready               result handshake
//   rsp_id, rsp_ct, rsp_tag, rsp_err  result payload
//   core_start                        one-cycle start pulse to the core
//   core_key/nonce/ad/pt              registered operands to the core
//   core_fin, core_ct, core_tag       core completion and result
//   busy                              arbiter not idle
module ascon_enc_arbiter #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned IDW         = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*128-1:0]  req_key,
    input  logic [NREQ*128-1:0]  req_nonce,
    input  logic [NREQ*40-1:0]   req_ad,
    input  logic [NREQ*40-1:0]   req_pt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [39:0]          rsp_ct,
    output logic [127:0]         rsp_tag,
    output logic                 rsp_err,
    output logic                 core_start,
    output logic [127:0]         core_key,
    output logic [127:0]         core_nonce,
    output logic [39:0]          core_ad,
    output logic [39:0]          core_pt,
    input  logic                 core_fin,
    input  logic [39:0]          core_ct,
    input  logic [127:0]         core_tag,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  winner;
    logic            any_valid;

`ifdef ASCON_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CW-1:0] wd_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // Search for the first valid requester, starting at ptr and wrapping
    // modulo NREQ. Only the first hit is kept.
    always_comb begin
        int unsigned    idx;
        logic [IDW-1:0] cand;
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx  = (32'(ptr) + k) % NREQ;
            cand = IDW'(idx);
            if (req_valid[cand] && !any_valid) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    // Grant is combinational and is only offered while idle. It is forced low
    // during reset so that every output reads 0 while rst is high.
    always_comb begin
        req_ready = '0;
        if (!rst && state == S_IDLE && any_valid)
            req_ready[winner] = 1'b1;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            core_start <= 1'b0;
            core_key   <= '0;
            core_nonce <= '0;
            core_ad    <= '0;
            core_pt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_ct     <= '0;
            rsp_tag    <= '0;
`ifdef ASCON_ARB_TIMEOUT_EN
            rsp_err    <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        core_key   <= req_key[32'(winner)*128 +: 128];
                        core_nonce <= req_nonce[32'(winner)*128 +: 128];
                        core_ad    <= req_ad[32'(winner)*40 +: 40];
                        core_pt    <= req_pt[32'(winner)*40 +: 40];
                        rsp_id     <= winner;
                        ptr        <= (32'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
                        core_start <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    core_start <= 1'b0;
`ifdef ASCON_ARB_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // If fin arrives in the same cycle the watchdog expires,
                    // the normal result is returned.
                    if (core_fin) begin
                        rsp_ct    <= core_ct;
                        rsp_tag   <= core_tag;
                        rsp_valid <= 1'b1;
`ifdef ASCON_ARB_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= S_RESP;
                    end
`ifdef ASCON_ARB_TIMEOUT_EN
                    else if (wd_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        rsp_ct    <= '0;
                        rsp_tag   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wd_cnt    <= wd_cnt + CW'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_enc_arbiter.sv
// tb_ascon_enc_arbiter
//   Directed bench for ascon_enc_arbiter with NREQ=2. A core stub raises fin
//   12 cycles after start and returns ct = pt ^ key[39:0] and tag = nonce.
//   Stimulus pushes the expected responses into a queue. A monitor pops one
//   entry at each rising edge of rsp_valid and compares it.
module tb_ascon_enc_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, req_ready;
    logic [NREQ*128-1:0] req_key, req_nonce;
    logic [NREQ*40-1:0]  req_ad, req_pt;
    logic                rsp_valid, rsp_ready, rsp_err;
    logic [IDW-1:0]      rsp_id;
    logic [39:0]         rsp_ct;
    logic [127:0]        rsp_tag;
    logic                core_start, core_fin, busy;
    logic [127:0]        core_key, core_nonce, core_tag;
    logic [39:0]         core_ad, core_pt, core_ct;

    ascon_enc_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad), .req_pt(req_pt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_ct(rsp_ct), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .core_start(core_start), .core_key(core_key), .core_nonce(core_nonce),
        .core_ad(core_ad), .core_pt(core_pt),
        .core_fin(core_fin), .core_ct(core_ct), .core_tag(core_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Requester operands and expected results, computed by hand.
    localparam logic [127:0] KEY0   = 128'h3ffa75efbd1705fa8f9ced62e5bb0be3;
    localparam logic [127:0] NONCE0 = 128'h9691163337dd55217ea2a6b21eaa19b2;
    localparam logic [39:0]  AD0    = 40'h4153434f4e;
    localparam logic [39:0]  PT0    = 40'h6173636f6e;
    localparam logic [39:0]  CT0    = 40'h0396d8648d;   // 6173636f6e ^ 62e5bb0be3
    localparam logic [127:0] KEY1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] NONCE1 = 128'hfedcba98765432100123456789abcdef;
    localparam logic [39:0]  AD1    = 40'h1111111111;
    localparam logic [39:0]  PT1    = 40'h0102030405;
    localparam logic [39:0]  CT1    = 40'hbacedeeafa;   // 0102030405 ^ bbccddeeff

    assign req_key   = {KEY1, KEY0};
    assign req_nonce = {NONCE1, NONCE0};
    assign req_ad    = {AD1, AD0};
    assign req_pt    = {PT1, PT0};

    // Core stub. spur_fin injects a stray fin and also corrupts core_ct, so
    // that a wrongful capture of the result is visible.
    logic       stub_fin, spur_fin, never_fin, armed;
    logic [3:0] cd;
    assign core_fin = stub_fin | spur_fin;
    assign core_ct  = (core_pt ^ core_key[39:0]) ^ {40{spur_fin}};
    assign core_tag = core_nonce;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            armed    <= 1'b0;
            cd       <= '0;
            stub_fin <= 1'b0;
        end else begin
            stub_fin <= 1'b0;
            if (core_start) begin
                armed <= !never_fin;
                cd    <= 4'd10;
            end else if (armed) begin
                if (cd == 0) begin
                    stub_fin <= 1'b1;
                    armed    <= 1'b0;
                end else begin
                    cd <= cd - 4'd1;
                end
            end
        end
    end

    // Scoreboard
    typedef struct {
        logic [IDW-1:0] id;
        logic [39:0]    ct;
        logic [127:0]   tag;
        logic           err;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, last_xfer = 0, xfer_cnt = 0, start_cnt = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [39:0] ct,
                        input logic [127:0] tag, input logic err, input int lat);
        exp_t e;
        e.id = id; e.ct = ct; e.tag = tag; e.err = err; e.lat = lat;
        sb.push_back(e);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (req_valid & req_ready) != '0) begin
            last_xfer = cyc;
            xfer_cnt++;
        end
        if (core_start) start_cnt++;
        if (rsp_valid && !prev_v) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 128'(sb.size()), 128'd1);
            end else begin
                e = sb.pop_front();
                check("rsp_id",  128'(rsp_id), 128'(e.id));
                check("rsp_ct",  128'(rsp_ct), 128'(e.ct));
                check("rsp_tag", rsp_tag, e.tag);
                check("rsp_err", 128'(rsp_err), 128'(e.err));
                check("rsp_latency", 128'(cyc - last_xfer), 128'(e.lat));
            end
        end
        prev_v = rsp_valid;
    end

    // Stimulus helpers
    task automatic job(input int id);
        int n = 0;
        @(posedge clk); #1;
        req_valid[id] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 200);
        check("grant_onehot", 128'(req_ready), 128'(1 << id));
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 128'(sb.size()), 128'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rsp_valid(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_seen", 128'(rsp_valid), 128'd1);
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int s0, x0, n;
        logic [NREQ-1:0] rdy_or;
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
        spur_fin = 1'b0; never_fin = 1'b0;

        // Reset state; the grant must stay low even with requests pending
        repeat (2) @(negedge clk);
        check("reset_req_ready", 128'(req_ready), 128'd0);
        check("reset_flags", 128'({busy, core_start, rsp_valid, rsp_err}), 128'd0);
        check("reset_rsp", {rsp_ct, rsp_tag[87:0]} | 128'(rsp_id), 128'd0);
        check("reset_core_ops", core_key | core_nonce | 128'(core_ad) | 128'(core_pt), 128'd0);
        req_valid = '0;
        @(posedge clk); #1 rst = 1'b0;

        // 1: single job from requester 0
        push(0, CT0, NONCE0, 1'b0, 14);
        s0 = start_cnt;
        job(0);
        drain(100);
        check("t1_start_count", 128'(start_cnt - s0), 128'd1);
        check("t1_core_key", core_key, KEY0);
        check("t1_core_nonce", core_nonce, NONCE0);
        check("t1_core_ad", 128'(core_ad), 128'(AD0));
        check("t1_core_pt", 128'(core_pt), 128'(PT0));

        // 2: both requesters hold valid; grants alternate starting from 0
        do_reset();
        push(0, CT0, NONCE0, 1'b0, 14);
        push(1, CT1, NONCE1, 1'b0, 14);
        push(0, CT0, NONCE0, 1'b0, 14);
        push(1, CT1, NONCE1, 1'b0, 14);
        x0 = xfer_cnt;
        @(posedge clk); #1 req_valid = 2'b11;
        n = 0;
        while (xfer_cnt < x0 + 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1 req_valid = '0;
        check("t2_xfer_count", 128'(xfer_cnt - x0), 128'd4);
        drain(100);

        // 3: back-pressure on the response holds everything
        rsp_ready = 1'b0;
        push(0, CT0, NONCE0, 1'b0, 14);
        push(1, CT1, NONCE1, 1'b0, 14);
        s0 = start_cnt;
        job(0);
        wait_rsp_valid(100);
        req_valid[1] = 1'b1;
        rdy_or = '0;
        repeat (20) begin
            @(negedge clk);
            rdy_or |= req_ready;
        end
        check("t3_ready_held_low", 128'(rdy_or), 128'd0);
        check("t3_start_count", 128'(start_cnt - s0), 128'd1);
        check("t3_rsp_valid_held", 128'(rsp_valid), 128'd1);
        check("t3_rsp_ct_held", 128'(rsp_ct), 128'(CT0));
        check("t3_rsp_tag_held", rsp_tag, NONCE0);
        check("t3_rsp_id_held", 128'(rsp_id), 128'd0);
        rsp_ready = 1'b1;
        job(1);
        drain(100);

        // 4: reset in WAIT clears outputs without waiting for an edge
        job(0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_flags", 128'({busy, core_start, rsp_valid, rsp_err}), 128'd0);
        check("t4_rst_req_ready", 128'(req_ready), 128'd0);
        check("t4_rst_core_ops", core_key | core_nonce | 128'(core_ad) | 128'(core_pt), 128'd0);
        @(posedge clk); #1 rst = 1'b0;
        push(1, CT1, NONCE1, 1'b0, 14);
        job(1);
        drain(100);

        // 5: stray fin in IDLE and in RESP is ignored
        @(negedge clk) spur_fin = 1'b1;
        @(negedge clk) spur_fin = 1'b0;
        check("t5_idle_busy", 128'({busy, rsp_valid}), 128'd0);
        check("t5_idle_rsp_ct", 128'(rsp_ct), 128'(CT1));
        rsp_ready = 1'b0;
        push(0, CT0, NONCE0, 1'b0, 14);
        job(0);
        wait_rsp_valid(100);
        @(negedge clk) spur_fin = 1'b1;
        @(negedge clk) spur_fin = 1'b0;
        check("t5_resp_state", 128'({busy, rsp_valid}), 128'd3);
        check("t5_resp_ct", 128'(rsp_ct), 128'(CT0));
        rsp_ready = 1'b1;
        drain(100);

`ifdef ASCON_ARB_TIMEOUT_EN
        // 6: the watchdog fires 16 cycles into WAIT (transfer + 2 + 16)
        never_fin = 1'b1;
        push(0, 40'h0, 128'h0, 1'b1, 18);
        job(0);
        drain(100);
        never_fin = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
